// File: rtl/msb_div_ctrl.sv
// Multi-cycle restoring divider for 32-bit signed/unsigned operands.
// The divisor is pre-aligned to the dividend's leading one, so only the significant quotient bits are iterated.
module msb_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              div_by_zero
);

  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] a_lat;
  logic [DATA_W-1:0] b_lat;
  logic              sgn;
  logic [DATA_W-1:0] abs_a;
  logic [DATA_W-1:0] abs_b;
  logic [IDX_W:0]    count;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] rem;
  logic [IDX_W-1:0]  ma;
  logic [IDX_W-1:0]  mb;
  logic [IDX_W-1:0]  shamt;

  // Index of the highest set bit; zero input reports 0.
  function automatic logic [IDX_W-1:0] lead_one(input logic [DATA_W-1:0] x);
    lead_one = '0;
    for (int i = 0; i < DATA_W; i++)
      if (x[i]) lead_one = i[IDX_W-1:0];
  endfunction

  // Two's-complement negate when c is set; wraps mod 2^DATA_W, so the most negative value maps to itself.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x, input logic c);
    cond_neg = c ? ('0 - x) : x;
  endfunction

  always_comb begin
    ma    = lead_one(abs_a);
    mb    = lead_one(abs_b);
    shamt = ma - mb;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      a_lat       <= '0;
      b_lat       <= '0;
      sgn         <= 1'b0;
      abs_a       <= '0;
      abs_b       <= '0;
      count       <= '0;
      d           <= '0;
      q           <= '0;
      rem         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_lat       <= a;
            b_lat       <= b;
            sgn         <= is_signed;
            abs_a       <= cond_neg(a, is_signed && a[DATA_W-1]);
            abs_b       <= cond_neg(b, is_signed && b[DATA_W-1]);
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            state       <= SETUP;
          end
        end
        SETUP: begin
          if (b_lat == '0) begin
            div_by_zero <= 1'b1;
            quotient    <= '1;
            remainder   <= a_lat;
            done        <= 1'b1;
            state       <= DONE;
          end else if (abs_a < abs_b) begin
            q     <= '0;
            rem   <= abs_a;
            state <= FIXUP;
          end else begin
            // ma >= mb here, so the aligned divisor cannot overflow
            count <= {1'b0, shamt} + 1'b1;
            d     <= abs_b << shamt;
            q     <= '0;
            rem   <= abs_a;
            state <= ITER;
          end
        end
        ITER: begin
          if (rem >= d) begin
            rem <= rem - d;
            q   <= {q[DATA_W-2:0], 1'b1};
          end else begin
            q   <= {q[DATA_W-2:0], 1'b0};
          end
          d     <= d >> 1;
          count <= count - 1'b1;
          if (count == 1) state <= FIXUP;
        end
        FIXUP: begin
          quotient  <= cond_neg(q, sgn && (a_lat[DATA_W-1] ^ b_lat[DATA_W-1]));
          remainder <= cond_neg(rem, sgn && a_lat[DATA_W-1]);
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
